// File: rtl/interrupt_line_conditioner_if.sv
// Register-bus request signals shared by the masters and the interrupt line conditioner.
// The tristated data and function-complete lines stay as direct module ports so they
// resolve on the shared board-level bus alongside other slaves.
`timescale 1ns/1ps
interface interrupt_line_conditioner_if;
    logic [31:0] addr_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;

    modport master (
        output addr_bus,
        output rd_bus,
        output wr_bus,
        output data_mask_bus
    );

    modport slave (
        input addr_bus,
        input rd_bus,
        input wr_bus,
        input data_mask_bus
    );
endinterface

// File: rtl/interrupt_line_conditioner.sv
// Interrupt line conditioner: per line a two-flop synchroniser, optional polarity
// inversion and a debounce counter, then a level or rising-edge pulse request.
// MODE / POLARITY / DEBOUNCE / STATUS registers sit on the shared system bus.
`timescale 1ns/1ps
module interrupt_line_conditioner #(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          LINES          = 16,
    parameter logic [15:0] DEBOUNCE_RESET = 16'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    interrupt_line_conditioner_if.slave   bus,
    inout  wire  [31:0]                   data_bus,
    output wire                           fc_bus,
    input  logic [LINES-1:0]              raw_irqs,
    output logic [LINES-1:0]              intr_reqs
);

    logic [29:0]      rel_word;
    logic             hit;
    logic [1:0]       sel;
    logic [1:0]       off;
    logic             read_req;
    logic             write_req;
    logic             wr_pulse;
    logic             pol_wr;
    logic [31:0]      reg_rd;
    logic [31:0]      rdata;
    logic [31:0]      wmask;
    logic [31:0]      merged;
    logic             unused_merge;

    logic [LINES-1:0] s1_q, s2_q;
    logic [LINES-1:0] stable_q, stable_d;
    logic [LINES-1:0] intr_q, intr_d;
    logic [LINES-1:0] mode_q, mode_d;
    logic [LINES-1:0] pol_q, pol_d;
    logic [15:0]      deb_q, deb_d;
    logic             written_q;

    // Address decode: four consecutive words starting at BASE_ADDR.
    assign rel_word  = bus.addr_bus[31:2] - BASE_ADDR[31:2];
    assign hit       = (rel_word[29:2] == 28'd0);
    assign sel       = rel_word[1:0];
    assign off       = bus.addr_bus[1:0];
    assign read_req  = hit & bus.rd_bus & ~bus.wr_bus;
    assign write_req = hit & bus.wr_bus & ~bus.rd_bus;
    // A held write updates the register once, on its first edge.
    assign wr_pulse  = write_req & ~written_q;
    assign pol_wr    = wr_pulse & (sel == 2'd1);

    // Select the addressed register, zero-extended to the bus width.
    always_comb begin
        case (sel)
            2'd0:    reg_rd = 32'(mode_q);
            2'd1:    reg_rd = 32'(pol_q);
            2'd2:    reg_rd = 32'(deb_q);
            default: reg_rd = {16'(s2_q), 16'(stable_q)};
        endcase
    end

    assign rdata    = reg_rd >> {off, 3'b000};
    assign data_bus = read_req ? rdata : 32'bz;
    assign fc_bus   = read_req ? 1'b1 : (write_req ? written_q : 1'bz);

    assign wmask  = {{8{bus.data_mask_bus[3]}}, {8{bus.data_mask_bus[2]}},
                     {8{bus.data_mask_bus[1]}}, {8{bus.data_mask_bus[0]}}};
    assign merged = (reg_rd & ~wmask) | (data_bus & wmask);
    // No writable register is wider than 16 bits.
    assign unused_merge = ^merged[31:16];

    // Configuration register next state from a byte-masked write; STATUS ignores writes.
    always_comb begin
        mode_d = mode_q;
        pol_d  = pol_q;
        deb_d  = deb_q;
        if (wr_pulse) begin
            case (sel)
                2'd0:    mode_d = merged[LINES-1:0];
                2'd1:    pol_d  = merged[LINES-1:0];
                2'd2:    deb_d  = merged[15:0];
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            logic        eff;
            logic        st_d;
            logic [15:0] cnt_q, cnt_d;
            logic [16:0] cnt_inc;

            assign eff     = s2_q[gi] ^ pol_q[gi];
            // One bit wider so the compare against the threshold never wraps.
            assign cnt_inc = {1'b0, cnt_q} + 17'd1;

            // Debounce: commit a mismatch once it has persisted for the threshold.
            always_comb begin
                st_d  = stable_q[gi];
                cnt_d = 16'd0;
                if (pol_wr) begin
                    // Polarity change re-seeds the line without debouncing.
                    st_d = s2_q[gi] ^ pol_d[gi];
                end else if (eff != stable_q[gi]) begin
                    if (cnt_inc >= {1'b0, deb_q}) begin
                        st_d = eff;
                    end else begin
                        cnt_d = cnt_inc[15:0];
                    end
                end
            end

            assign stable_d[gi] = st_d;
            // Edge lines pulse on a rising stable value, but never on a polarity re-seed.
            assign intr_d[gi]   = mode_d[gi] ? (st_d & ~stable_q[gi] & ~pol_wr) : st_d;

            // Per-line debounce counter.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= 16'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Synchronisers, stable state, registered requests and configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            intr_q    <= '0;
            mode_q    <= '0;
            pol_q     <= '0;
            deb_q     <= DEBOUNCE_RESET;
            written_q <= 1'b0;
        end else begin
            s1_q      <= raw_irqs;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            intr_q    <= intr_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            deb_q     <= deb_d;
            written_q <= write_req;
        end
    end

    assign intr_reqs = intr_q;

endmodule
